// File: rtl/ttl_74299_if.sv
// Bus bundle for the ttl_74299 universal shift/storage register.
// Parity tap P is present only when TTL_74299_PARITY_EN is defined.
interface ttl_74299_if #(
  parameter int WIDTH = 8
);
  // Static register bus, no handshake: the master holds S/DSR/DSL/D stable
  // around each rising Clk edge; IO is meaningful only while IO_oe is high.
  logic [1:0]       S;
  logic             DSR;
  logic             DSL;
  logic             OE1_bar;
  logic             OE2_bar;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] IO;
  logic             IO_oe;
  logic             Q0;
  logic             Q7;
`ifdef TTL_74299_PARITY_EN
  logic             P;
`endif

  modport master (
    output S, DSR, DSL, OE1_bar, OE2_bar, D,
`ifdef TTL_74299_PARITY_EN
    input  P,
`endif
    input  IO, IO_oe, Q0, Q7
  );

  modport slave (
    input  S, DSR, DSL, OE1_bar, OE2_bar, D,
`ifdef TTL_74299_PARITY_EN
    output P,
`endif
    output IO, IO_oe, Q0, Q7
  );
endinterface

// File: rtl/ttl_74299.sv
// 74299-style universal shift/storage register with split 3-state bus.
// Optional even-parity output P enabled by defining TTL_74299_PARITY_EN.
module ttl_74299 #(
  parameter int WIDTH      = 8,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input logic        Clk,
  input logic        Clear_bar,
  ttl_74299_if.slave bus
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  // Outputs are zero-delay here; the delay parameters exist so netlists that
  // set them still elaborate, and only sanity-checked.
  if (WIDTH < 2 || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_param_check
    $error("ttl_74299: WIDTH must be >= 2 and delays non-negative");
  end

  logic [WIDTH-1:0] r;

  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      r <= '0;
    end else begin
      case (bus.S)
        MODE_HOLD:  r <= r;
        MODE_RIGHT: r <= {r[WIDTH-2:0], bus.DSR};
        MODE_LEFT:  r <= {bus.DSL, r[WIDTH-1:1]};
        MODE_LOAD:  r <= bus.D;
        // Unknown mode poisons the register so misuse shows up in simulation.
        default:    r <= 'x;
      endcase
    end
  end

  // Bus is released during load so D can be sampled without contention.
  assign bus.IO_oe = !bus.OE1_bar && !bus.OE2_bar && (bus.S != MODE_LOAD);
  assign bus.IO    = r;
  assign bus.Q0    = r[0];
  assign bus.Q7    = r[WIDTH-1];

`ifdef TTL_74299_PARITY_EN
  assign bus.P     = ^r;
`endif

endmodule

// File: tb/tb_ttl_74299.sv
// Directed self-checking bench for ttl_74299, including a two-stage cascade.
// Parity checks run when TTL_74299_PARITY_EN is defined.
module tb_ttl_74299;

  localparam int WIDTH = 8;

  logic clk;
  logic clear_bar;
  int   checks;
  int   failures;

  ttl_74299_if #(.WIDTH(WIDTH)) bus0 ();
  ttl_74299_if #(.WIDTH(WIDTH)) bus1 ();

  ttl_74299 #(.WIDTH(WIDTH), .DELAY_RISE(0), .DELAY_FALL(0)) u_dut0 (
    .Clk       (clk),
    .Clear_bar (clear_bar),
    .bus       (bus0.slave)
  );

  ttl_74299 #(.WIDTH(WIDTH), .DELAY_RISE(0), .DELAY_FALL(0)) u_dut1 (
    .Clk       (clk),
    .Clear_bar (clear_bar),
    .bus       (bus1.slave)
  );

  // Cascade: stage 0 top bit feeds stage 1 serial-right input.
  assign bus1.DSR = bus0.Q7;

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic [1:0] s, input logic [WIDTH-1:0] d,
                        input logic dsr, input logic dsl);
    bus0.S   = s;
    bus0.D   = d;
    bus0.DSR = dsr;
    bus0.DSL = dsl;
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    clear_bar = 1'b0;
    drive0(2'b00, '0, 1'b0, 1'b0);
    bus0.OE1_bar = 1'b1;
    bus0.OE2_bar = 1'b1;
    bus1.S       = 2'b00;
    bus1.D       = '0;
    bus1.DSL     = 1'b0;
    bus1.OE1_bar = 1'b1;
    bus1.OE2_bar = 1'b1;
    step();
    step();

    check("reset_io",    bus0.IO,    8'h00);
    check("reset_q0",    bus0.Q0,    1'b0);
    check("reset_q7",    bus0.Q7,    1'b0);
    check("reset_io_oe", bus0.IO_oe, 1'b0);

    // Load A5 then clear asynchronously mid-cycle.
    clear_bar = 1'b1;
    drive0(2'b11, 8'hA5, 1'b0, 1'b0);
    step();
    check("load_a5", bus0.IO, 8'hA5);
    drive0(2'b00, 8'h00, 1'b0, 1'b0);
    bus0.OE1_bar = 1'b0;
    bus0.OE2_bar = 1'b0;
    #2;
    clear_bar = 1'b0;
    #1;
    check("async_clr_io", bus0.IO, 8'h00);
    check("async_clr_q0", bus0.Q0, 1'b0);
    check("async_clr_q7", bus0.Q7, 1'b0);
    drive0(2'b11, 8'hFF, 1'b0, 1'b0);
    step();
    check("clr_ignores_clk", bus0.IO, 8'h00);

    // First edge after clear release acts normally.
    clear_bar = 1'b1;
    drive0(2'b11, 8'h3C, 1'b0, 1'b0);
    step();
    check("load_3c",       bus0.IO,    8'h3C);
    check("load_io_oe",    bus0.IO_oe, 1'b0);
    drive0(2'b00, 8'h00, 1'b0, 1'b0);
    #1;
    check("hold_io_oe", bus0.IO_oe, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_3c", bus0.IO, 8'h3C);
    end

    // Shift right from 81 with DSR=0.
    drive0(2'b11, 8'h81, 1'b0, 1'b0);
    step();
    drive0(2'b01, 8'h00, 1'b0, 1'b0);
    step();
    check("shr_r",  bus0.IO, 8'h02);
    check("shr_q7", bus0.Q7, 1'b0);
    check("shr_q0", bus0.Q0, 1'b0);

    // Shift left from 81 with DSL=1.
    drive0(2'b11, 8'h81, 1'b0, 1'b0);
    step();
    drive0(2'b10, 8'h00, 1'b0, 1'b1);
    step();
    check("shl_r",  bus0.IO, 8'hC0);
    check("shl_q0", bus0.Q0, 1'b0);
    check("shl_q7", bus0.Q7, 1'b1);

    // Output-enable truth table, held mode so R stays C0.
    drive0(2'b00, 8'h00, 1'b0, 1'b0);
    bus0.OE1_bar = 1'b1; bus0.OE2_bar = 1'b1; #1;
    check("oe_11_hold", bus0.IO_oe, 1'b0);
    bus0.OE1_bar = 1'b0; bus0.OE2_bar = 1'b1; #1;
    check("oe_01_hold", bus0.IO_oe, 1'b0);
    bus0.OE1_bar = 1'b1; bus0.OE2_bar = 1'b0; #1;
    check("oe_10_hold", bus0.IO_oe, 1'b0);
    bus0.OE1_bar = 1'b0; bus0.OE2_bar = 1'b0; #1;
    check("oe_00_hold", bus0.IO_oe, 1'b1);
    step();
    drive0(2'b01, 8'h00, 1'b0, 1'b0);
    #1;
    check("oe_00_shr", bus0.IO_oe, 1'b1);
    drive0(2'b11, 8'hC0, 1'b0, 1'b0);
    #1;
    check("oe_00_load", bus0.IO_oe, 1'b0);
    check("q_ignore_oe", bus0.Q7, 1'b1);
    step();

    // Two-stage cascade: FF / 00, then 8 shift-right edges.
    drive0(2'b11, 8'hFF, 1'b0, 1'b0);
    bus1.S = 2'b11;
    bus1.D = 8'h00;
    step();
    check("casc_load0", bus0.IO, 8'hFF);
    check("casc_load1", bus1.IO, 8'h00);
    drive0(2'b01, 8'h00, 1'b0, 1'b0);
    bus1.S = 2'b01;
    step();
    check("casc_1edge0", bus0.IO, 8'hFE);
    check("casc_1edge1", bus1.IO, 8'h01);
    for (int i = 0; i < 7; i++) step();
    check("casc_8edge0", bus0.IO, 8'h00);
    check("casc_8edge1", bus1.IO, 8'hFF);
    bus1.S = 2'b00;
    drive0(2'b00, 8'h00, 1'b0, 1'b0);
    step();
    check("casc_hold1", bus1.IO, 8'hFF);

`ifdef TTL_74299_PARITY_EN
    check("par_clear_state", bus0.P, 1'b0);
    drive0(2'b11, 8'h07, 1'b0, 1'b0);
    step();
    check("par_07", bus0.P, 1'b1);
    drive0(2'b01, 8'h00, 1'b0, 1'b0);
    step();
    check("par_shr_r", bus0.IO, 8'h0E);
    check("par_0e",    bus0.P,  1'b1);
    drive0(2'b11, 8'h03, 1'b0, 1'b0);
    step();
    check("par_03", bus0.P, 1'b0);
    #2;
    clear_bar = 1'b0;
    drive0(2'b11, 8'h01, 1'b0, 1'b0);
    #1;
    check("par_in_clear", bus0.P, 1'b0);
    step();
    clear_bar = 1'b1;
`endif

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
